// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C responder: FSM state encoding,
// ACK/NACK levels and the bit-counter type.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_WAIT,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef logic [2:0] bit_cnt_t;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus-side and local-side signals of the I2C responder; the slave modport
// is the responder's view, the master modport is the view of whatever drives it.
interface i2c_slave_responder_if;

    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       sda_o;
    logic       start_o;
    logic       stop_o;
    logic       rw_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       tx_req_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;

    modport slave (
        input  scl_i, sda_i, tx_data_i, tx_valid_i,
        output scl_o, sda_o, start_o, stop_o, rw_o, rx_data_o, rx_valid_o, tx_req_o
    );

    modport master (
        output scl_i, sda_i, tx_data_i, tx_valid_i,
        input  scl_o, sda_o, start_o, stop_o, rw_o, rx_data_o, rx_valid_o, tx_req_o
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a DEPTH-sample glitch filter on one bus
// line; emits the filtered level and single-cycle rise/fall strobes.
module i2c_line_filter #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]       sync;
    logic [DEPTH-1:0] hist;

    // Level only moves once DEPTH consecutive synchronized samples agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '1;
            hist  <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            hist <= {hist[DEPTH-2:0], sync[1]};
            rise <= 1'b0;
            fall <= 1'b0;
            if (hist == '1 && !level) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end else if (hist == '0 && level) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: decodes START/STOP, matches one 7-bit address, ACKs written
// bytes to local logic and serves read bytes, stretching SCL until supplied.
module i2c_slave_responder #(
    parameter logic [6:0]  SLAVE_ADDRESS  = 7'h22,
    parameter int unsigned I2C_DATA_WIDTH = 8,
    parameter int unsigned FILTER_DEPTH   = 3
) (
    input logic                  clk_i,
    input logic                  rst_i,
    i2c_slave_responder_if.slave bus
);
    import i2c_slave_pkg::*;

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t                    state;
    bit_cnt_t                  bit_cnt;
    logic [I2C_DATA_WIDTH-1:0] shreg;
    logic                      ack_on;

    i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk   (clk_i),
        .rst   (rst_i),
        .line  (bus.scl_i),
        .level (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk   (clk_i),
        .rst   (rst_i),
        .line  (bus.sda_i),
        .level (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            ack_on         <= 1'b0;
            bus.scl_o      <= 1'b1;
            bus.sda_o      <= 1'b1;
            bus.start_o    <= 1'b0;
            bus.stop_o     <= 1'b0;
            bus.rw_o       <= 1'b0;
            bus.rx_data_o  <= '0;
            bus.rx_valid_o <= 1'b0;
            bus.tx_req_o   <= 1'b0;
        end else begin
            bus.start_o    <= 1'b0;
            bus.stop_o     <= 1'b0;
            bus.rx_valid_o <= 1'b0;
            bus.tx_req_o   <= 1'b0;
            if (start_det) begin
                state       <= ADDR;
                bit_cnt     <= '0;
                bus.start_o <= 1'b1;
                bus.sda_o   <= 1'b1;
                bus.scl_o   <= 1'b1;
            end else if (stop_det) begin
                state      <= IDLE;
                bus.stop_o <= 1'b1;
                bus.sda_o  <= 1'b1;
                bus.scl_o  <= 1'b1;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= {shreg[I2C_DATA_WIDTH-2:0], sda_f};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_on <= 1'b0;
                            if (shreg[I2C_DATA_WIDTH-2:0] == SLAVE_ADDRESS) begin
                                bus.rw_o <= sda_f;
                                state    <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // First fall drives ACK, second fall ends the ACK bit.
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            bus.sda_o <= ACK;
                            ack_on    <= 1'b1;
                        end else begin
                            bus.sda_o <= 1'b1;
                            ack_on    <= 1'b0;
                            bit_cnt   <= '0;
                            if (bus.rw_o) begin
                                bus.tx_req_o <= 1'b1;
                                state        <= RD_WAIT;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        shreg   <= {shreg[I2C_DATA_WIDTH-2:0], sda_f};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.rx_data_o  <= {shreg[I2C_DATA_WIDTH-2:0], sda_f};
                            bus.rx_valid_o <= 1'b1;
                            ack_on         <= 1'b0;
                            state          <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            bus.sda_o <= ACK;
                            ack_on    <= 1'b1;
                        end else begin
                            bus.sda_o <= 1'b1;
                            ack_on    <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= WR_DATA;
                        end
                    end
                    // Only act while SCL is low so SDA never moves during SCL high.
                    RD_WAIT: if (!scl_f) begin
                        if (bus.tx_valid_i) begin
                            shreg     <= {bus.tx_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
                            bus.sda_o <= bus.tx_data_i[I2C_DATA_WIDTH-1];
                            bus.scl_o <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= RD_DATA;
                        end else begin
                            bus.scl_o <= 1'b0;
                        end
                    end
                    RD_DATA: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            bus.sda_o <= 1'b1;
                            state     <= RD_ACK;
                        end else begin
                            bus.sda_o <= shreg[I2C_DATA_WIDTH-1];
                            shreg     <= {shreg[I2C_DATA_WIDTH-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (sda_f == ACK) begin
                            bus.tx_req_o <= 1'b1;
                            state        <= RD_WAIT;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
